// File: rtl/axis_packet_source.sv
// axis_packet_source
//   AXI-Stream packet generator. Each rising edge of the (asynchronous) start
//   button emits one packet of PKT_LEN beats, followed by GAP_CYC idle cycles.
//   Each 32-bit lane of a beat carries {pkt_id[15:0], beat[15:0]}. tlast marks
//   the final beat of a packet.
// Ports
//   clk            system clock, rising edge
//   resentn        asynchronous active-low reset
//   start          push-button level, not synchronous to clk
//   tdata/tvalid/tlast/tready  AXI-Stream master interface
//   busy           high while a packet or its trailing gap is in progress
//   sevenseg       count of fully sent packets, wraps at 32 bits
//   digital_enable constant digit enable for the display
module axis_packet_source #(
  parameter int DATA_W  = 256,
  parameter int PKT_LEN = 16,
  parameter int GAP_CYC = 4
) (
  input  logic              clk,
  input  logic              resentn,
  input  logic              start,
  output logic [DATA_W-1:0] tdata,
  output logic              tvalid,
  output logic              tlast,
  input  logic              tready,
  output logic              busy,
  output logic [31:0]       sevenseg,
  output logic [7:0]        digital_enable
);

  localparam int          WORDS     = DATA_W / 32;
  localparam logic [15:0] LAST_BEAT = 16'(PKT_LEN - 1);
  // Only used when GAP_CYC > 0; with no gap the FSM never enters GAP.
  localparam logic [7:0]  GAP_LAST  = 8'(GAP_CYC - 1);
  localparam logic        ONE_BEAT  = (PKT_LEN == 1);
  localparam logic        NO_GAP    = (GAP_CYC == 0);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t      state_reg;
  logic [15:0] beat_reg;
  logic [15:0] pkt_id_reg;
  logic [7:0]  gap_cnt_reg;
  logic        pending_reg;
  logic        start_meta_reg;
  logic        start_sync_reg;
  logic        start_prev_reg;
  logic        start_evt;
  logic [15:0] beat_next;

  assign digital_enable = 8'b0000_0001;
  assign start_evt      = start_sync_reg & ~start_prev_reg;
  assign beat_next      = beat_reg + 16'd1;

  // Replicate {pkt_id, beat} across every 32-bit lane of the beat.
  function automatic logic [DATA_W-1:0] beat_pattern(input logic [15:0] id,
                                                     input logic [15:0] b);
    logic [DATA_W-1:0] d;
    d = '0;
    for (int i = 0; i < WORDS; i++) d[i*32 +: 32] = {id, b};
    return d;
  endfunction

  // Two-flop synchronizer plus one history flop for rising-edge detection.
  always_ff @(posedge clk or negedge resentn) begin
    if (!resentn) begin
      start_meta_reg <= 1'b0;
      start_sync_reg <= 1'b0;
      start_prev_reg <= 1'b0;
    end else begin
      start_meta_reg <= start;
      start_sync_reg <= start_meta_reg;
      start_prev_reg <= start_sync_reg;
    end
  end

  always_ff @(posedge clk or negedge resentn) begin
    if (!resentn) begin
      state_reg   <= IDLE;
      beat_reg    <= '0;
      pkt_id_reg  <= '0;
      gap_cnt_reg <= '0;
      pending_reg <= 1'b0;
      tdata       <= '0;
      tvalid      <= 1'b0;
      tlast       <= 1'b0;
      busy        <= 1'b0;
      sevenseg    <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          // A start event arriving on this edge is absorbed by the packet
          // that begins here, so pending is simply cleared.
          if (start_evt || pending_reg) begin
            state_reg   <= SEND;
            beat_reg    <= '0;
            pending_reg <= 1'b0;
            pkt_id_reg  <= sevenseg[15:0];
            tdata       <= beat_pattern(sevenseg[15:0], 16'd0);
            tvalid      <= 1'b1;
            tlast       <= ONE_BEAT;
            busy        <= 1'b1;
          end
        end
        SEND: begin
          // Single-entry request queue; extra presses while pending are lost.
          if (start_evt) pending_reg <= 1'b1;
          // tvalid is always 1 in SEND, so tready alone marks the handshake.
          if (tready) begin
            if (beat_reg == LAST_BEAT) begin
              sevenseg    <= sevenseg + 32'd1;
              beat_reg    <= '0;
              gap_cnt_reg <= '0;
              tdata       <= '0;
              tvalid      <= 1'b0;
              tlast       <= 1'b0;
              if (NO_GAP) begin
                state_reg <= IDLE;
                busy      <= 1'b0;
              end else begin
                state_reg <= GAP;
              end
            end else begin
              beat_reg <= beat_next;
              tdata    <= beat_pattern(pkt_id_reg, beat_next);
              tlast    <= (beat_next == LAST_BEAT);
            end
          end
        end
        GAP: begin
          if (start_evt) pending_reg <= 1'b1;
          if (gap_cnt_reg == GAP_LAST) begin
            state_reg <= IDLE;
            busy      <= 1'b0;
          end else begin
            gap_cnt_reg <= gap_cnt_reg + 8'd1;
          end
        end
        default: begin
          state_reg <= IDLE;
          tvalid    <= 1'b0;
          tlast     <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
